dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port (DataMem: combinational read, write on clk) between two requesters.
- Port 0 is the pipeline memory-access stage. It has priority and uses a same-cycle request/stall interface.
- Port 1 is a secondary master (program loader / debug). It uses a valid/ready request channel and a registered response channel.
- A starvation counter guarantees port 1 forward progress. The block sits between the memory-access stage and DMEM.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles port 1 may be denied by port 0 before port 1 is forced through. Legal range 1..7.
- CNT_W, 3: width of the starvation counter. Must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  pipeline memory access this cycle (load or store).
- p0_wEn  in  1  pipeline store when 1, load when 0.
- p0_addr  in  32  pipeline byte address (ALU result).
- p0_size  in  2  access size, passed to DMEM Size.
- p0_sign  in  1  load sign-extend select.
- p0_wdata  in  32  store data.
- p0_stall  out  1  pipeline must hold its MEM stage this cycle.
- p0_rdata  out  32  load data, combinational from DMEM.
- p1_valid  in  1  port 1 request valid.
- p1_ready  out  1  port 1 request accepted this cycle.
- p1_wEn, p1_addr[31:0], p1_size[1:0], p1_sign, p1_wdata[31:0]  in  port 1 request fields. Meaning as for port 0.
- p1_rsp_valid  out  1  port 1 response available.
- p1_rsp_data  out  32  port 1 load data; 0 for writes.
- p1_rsp_ready  in  1  port 1 consumes response.
- mem_Addr  out  32  to DMEM Addr.
- mem_Size  out  2  to DMEM Size.
- mem_sign  out  1  to DMEM load_extend_sign.
- mem_DataIn  out  32  to DMEM DataIn.
- mem_WEN  out  1  to DMEM WEN.
- mem_DataOut  in  32  from DMEM DataOut.

Behaviour:
- State: IDLE (no port 1 response held) and RSP (p1_rsp_valid=1).
- Reset:
  - state=IDLE, starve_cnt=0, p1_rsp_valid=0, p1_rsp_data=0.
  - While reset=1: p1_ready=0, mem_WEN=0, p0_stall=p0_req. Reset asserted mid-response drops the pending response without handshake.
- slot_free = (state==IDLE) | p1_rsp_ready.
- Grant to port 1 (combinational): grant1 = p1_valid & slot_free & (~p0_req | starve_cnt==STARVE_LIMIT).
- Port 1 outputs: p1_ready = grant1. p0_stall = p0_req & grant1.
- DMEM mux:
  - If grant1: drive port 1 fields, mem_WEN = p1_wEn.
  - Else if p0_req: drive port 0 fields, mem_WEN = p0_wEn.
  - Else: mem_Addr=0, mem_DataIn=0, mem_Size=0, mem_sign=0, mem_WEN=0.
- Write timing: a write takes effect at the clk edge ending the granted cycle.
- p0_rdata = mem_DataOut at all times. It is valid only when p0_req & ~p0_stall (zero-latency load).
- Port 1 response latency 1 cycle:
  - On grant1, at the next edge: p1_rsp_valid←1, p1_rsp_data←(p1_wEn ? 0 : mem_DataOut), state←RSP.
  - Response held stable until p1_rsp_valid & p1_rsp_ready.
  - If consumed with no new grant: state←IDLE, p1_rsp_valid←0.
  - Consume plus new grant in the same cycle: state stays RSP and new data loads. This sustains 1 transfer/cycle.
- Starvation counter (starve_cnt):
  - If grant1: ←0.
  - Else if p1_valid & slot_free & p0_req: ←min(starve_cnt+1, STARVE_LIMIT).
  - Else if ~p1_valid: ←0.
  - Else (blocked only by pending response): hold.
- Forced cycle: with port 1 continuously blocked by port 0, grant1 occurs on the (STARVE_LIMIT+1)-th waiting cycle. The pipeline stalls exactly that one cycle, then regains priority.
- No address alignment checking. Size and sign pass through unchanged.

Test Plan:
- Port 0 only: store 0xDEADBEEF to 0x10 (size word), next cycle load 0x10 -> p0_stall=0 both cycles, p0_rdata=0xDEADBEEF in load cycle.
- Port 1 only: write 0x12345678 @0x20, then read @0x20 with p1_rsp_ready=1 -> p1_ready=1 each cycle, p1_rsp_valid 1 cycle after each, rsp_data 0 then 0x12345678.
- Starvation with STARVE_LIMIT=4: p0_req held 1, p1_valid=1 -> p1_ready=0 for 4 cycles, p1_ready=1 and p0_stall=1 on cycle 5, p0_stall=0 on cycle 6, starve_cnt=0.
- Backpressure: p1_rsp_ready=0 after a read grant -> p1_rsp_valid/data held, p1_ready=0 for a new request. Port 0 accesses proceed unstalled. Raising rsp_ready with p1_valid=1 and p0_req=0 -> consume and accept in the same cycle.
- Idle bus: no requests -> mem_WEN=0, mem_Addr=0. A port 0 load of a byte @0x23 with sign=1 passes size=0/sign=1 to DMEM.
- Reset mid-operation: reset during RSP with p0_req=1 -> p0_stall=1, p1_ready=0, mem_WEN=0. After release: p1_rsp_valid=0, starve_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the pipeline MEM stage has priority, and a
// loader/debug master is served through a valid/ready channel with starvation relief.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_wEn,
    input  logic [31:0] p0_addr,
    input  logic [1:0]  p0_size,
    input  logic        p0_sign,
    input  logic [31:0] p0_wdata,
    output logic        p0_stall,
    output logic [31:0] p0_rdata,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_wEn,
    input  logic [31:0] p1_addr,
    input  logic [1:0]  p1_size,
    input  logic        p1_sign,
    input  logic [31:0] p1_wdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_data,
    input  logic        p1_rsp_ready,
    output logic [31:0] mem_Addr,
    output logic [1:0]  mem_Size,
    output logic        mem_sign,
    output logic [31:0] mem_DataIn,
    output logic        mem_WEN,
    input  logic [31:0] mem_DataOut
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RSP  = 1'b1;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [0:0]       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             slot_free;
    logic             at_limit;
    logic             grant1;

    assign slot_free = (state == IDLE) | p1_rsp_ready;
    assign at_limit  = (starve_cnt == LIMIT);
    assign grant1    = ~reset & p1_valid & slot_free & (~p0_req | at_limit);

    assign p1_ready  = grant1;
    assign p0_stall  = p0_req & (grant1 | reset);
    assign p0_rdata  = mem_DataOut;

    // Steer the single DMEM port to the granted requester; idle bus drives zeros.
    always_comb begin
        mem_Addr   = '0;
        mem_Size   = '0;
        mem_sign   = 1'b0;
        mem_DataIn = '0;
        mem_WEN    = 1'b0;
        if (grant1) begin
            mem_Addr   = p1_addr;
            mem_Size   = p1_size;
            mem_sign   = p1_sign;
            mem_DataIn = p1_wdata;
            mem_WEN    = p1_wEn;
        end else if (p0_req) begin
            mem_Addr   = p0_addr;
            mem_Size   = p0_size;
            mem_sign   = p0_sign;
            mem_DataIn = p0_wdata;
            mem_WEN    = p0_wEn & ~reset;
        end
    end

    // Port 1 response register: load on grant, clear on consume, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            p1_rsp_valid <= 1'b0;
            p1_rsp_data  <= '0;
        end else if (grant1) begin
            state        <= RSP;
            p1_rsp_valid <= 1'b1;
            p1_rsp_data  <= p1_wEn ? 32'd0 : mem_DataOut;
        end else if (p1_rsp_valid & p1_rsp_ready) begin
            state        <= IDLE;
            p1_rsp_valid <= 1'b0;
        end
    end

    // Count cycles port 1 loses to port 0; saturate at the limit to force a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant1) begin
            starve_cnt <= '0;
        end else if (p1_valid & slot_free & p0_req) begin
            if (!at_limit)
                starve_cnt <= starve_cnt + 1'b1;
        end else if (!p1_valid) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed DMEM model
// (combinational read with size/sign handling, write on clk).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_wEn, p0_sign;
    logic [31:0] p0_addr, p0_wdata;
    logic [1:0]  p0_size;
    logic        p0_stall;
    logic [31:0] p0_rdata;
    logic        p1_valid, p1_ready, p1_wEn, p1_sign;
    logic [31:0] p1_addr, p1_wdata;
    logic [1:0]  p1_size;
    logic        p1_rsp_valid, p1_rsp_ready;
    logic [31:0] p1_rsp_data;
    logic [31:0] mem_Addr, mem_DataIn, mem_DataOut;
    logic [1:0]  mem_Size;
    logic        mem_sign, mem_WEN;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_wEn(p0_wEn), .p0_addr(p0_addr),
        .p0_size(p0_size), .p0_sign(p0_sign), .p0_wdata(p0_wdata),
        .p0_stall(p0_stall), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_wEn(p1_wEn),
        .p1_addr(p1_addr), .p1_size(p1_size), .p1_sign(p1_sign),
        .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_data(p1_rsp_data), .p1_rsp_ready(p1_rsp_ready),
        .mem_Addr(mem_Addr), .mem_Size(mem_Size), .mem_sign(mem_sign),
        .mem_DataIn(mem_DataIn), .mem_WEN(mem_WEN),
        .mem_DataOut(mem_DataOut)
    );

    // DMEM read path
    always_comb begin
        logic [7:0] a;
        a = mem_Addr[7:0];
        mem_DataOut = '0;
        case (mem_Size)
            2'd0: mem_DataOut = {{24{mem_sign & mem[a][7]}}, mem[a]};
            2'd1: mem_DataOut = {{16{mem_sign & mem[a+8'd1][7]}},
                                 mem[a+8'd1], mem[a]};
            default: mem_DataOut = {mem[a+8'd3], mem[a+8'd2],
                                    mem[a+8'd1], mem[a]};
        endcase
    end

    // DMEM write path
    always @(posedge clk) begin
        if (mem_WEN) begin
            mem[mem_Addr[7:0]] <= mem_DataIn[7:0];
            if (mem_Size != 2'd0)
                mem[mem_Addr[7:0]+8'd1] <= mem_DataIn[15:8];
            if (mem_Size[1]) begin
                mem[mem_Addr[7:0]+8'd2] <= mem_DataIn[23:16];
                mem[mem_Addr[7:0]+8'd3] <= mem_DataIn[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p0_req = 0; p0_wEn = 0; p0_addr = 0; p0_size = 0;
        p0_sign = 0; p0_wdata = 0;
        p1_valid = 0; p1_wEn = 0; p1_addr = 0; p1_size = 0;
        p1_sign = 0; p1_wdata = 0; p1_rsp_ready = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        clear_inputs();
        reset = 1;
        cyc();
        // reset behaviour with requests present
        p0_req = 1; p0_wEn = 1; p1_valid = 1;
        #1;
        chk("rst_stall", 32'(p0_stall), 32'd1);
        chk("rst_p1rdy", 32'(p1_ready), 32'd0);
        chk("rst_wen", 32'(mem_WEN), 32'd0);
        cyc();
        clear_inputs();
        reset = 0;
        cyc();
        chk("rst_rspv", 32'(p1_rsp_valid), 32'd0);
        chk("rst_rspd", p1_rsp_data, 32'd0);
        chk("rst_cnt", 32'(dut.starve_cnt), 32'd0);

        // port 0 store then load
        p0_req = 1; p0_wEn = 1; p0_addr = 32'h10; p0_size = 2;
        p0_wdata = 32'hDEADBEEF;
        #1;
        chk("p0_st_stall", 32'(p0_stall), 32'd0);
        chk("p0_st_wen", 32'(mem_WEN), 32'd1);
        cyc();
        p0_wEn = 0;
        #1;
        chk("p0_ld_stall", 32'(p0_stall), 32'd0);
        chk("p0_ld_data", p0_rdata, 32'hDEADBEEF);
        cyc();
        clear_inputs();

        // port 1 write then read, response always consumed
        p1_valid = 1; p1_wEn = 1; p1_addr = 32'h20; p1_size = 2;
        p1_wdata = 32'h12345678; p1_rsp_ready = 1;
        #1;
        chk("p1_wr_rdy", 32'(p1_ready), 32'd1);
        cyc();
        chk("p1_wr_rspv", 32'(p1_rsp_valid), 32'd1);
        chk("p1_wr_rspd", p1_rsp_data, 32'd0);
        p1_wEn = 0;
        #1;
        chk("p1_rd_rdy", 32'(p1_ready), 32'd1);
        cyc();
        chk("p1_rd_rspv", 32'(p1_rsp_valid), 32'd1);
        chk("p1_rd_rspd", p1_rsp_data, 32'h12345678);
        p1_valid = 0;
        cyc();
        chk("p1_drain", 32'(p1_rsp_valid), 32'd0);

        // starvation: port 0 hogs the bus
        p0_req = 1; p0_wEn = 0; p0_addr = 32'h10; p0_size = 2;
        p1_valid = 1; p1_wEn = 0; p1_addr = 32'h20; p1_size = 2;
        p1_rsp_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("stv_rdy%0d", i), 32'(p1_ready), 32'd0);
            chk($sformatf("stv_stall%0d", i), 32'(p0_stall), 32'd0);
            cyc();
        end
        #1;
        chk("stv_force_rdy", 32'(p1_ready), 32'd1);
        chk("stv_force_stall", 32'(p0_stall), 32'd1);
        chk("stv_force_addr", mem_Addr, 32'h20);
        cyc();
        chk("stv_rspd", p1_rsp_data, 32'h12345678);
        chk("stv_cnt0", 32'(dut.starve_cnt), 32'd0);
        #1;
        chk("stv_after_stall", 32'(p0_stall), 32'd0);
        chk("stv_after_rdy", 32'(p1_ready), 32'd0);
        chk("stv_after_rdata", p0_rdata, 32'hDEADBEEF);
        cyc();
        clear_inputs();
        cyc();

        // backpressure on the response channel
        p1_valid = 1; p1_wEn = 0; p1_addr = 32'h10; p1_size = 2;
        p1_rsp_ready = 0;
        #1;
        chk("bp_rdy1", 32'(p1_ready), 32'd1);
        cyc();
        chk("bp_rspd1", p1_rsp_data, 32'hDEADBEEF);
        p1_addr = 32'h20;
        p0_req = 1; p0_wEn = 1; p0_addr = 32'h30; p0_size = 2;
        p0_wdata = 32'hA5A5A5A5;
        #1;
        chk("bp_rdy_blk", 32'(p1_ready), 32'd0);
        chk("bp_p0_stall", 32'(p0_stall), 32'd0);
        chk("bp_p0_addr", mem_Addr, 32'h30);
        chk("bp_p0_wen", 32'(mem_WEN), 32'd1);
        cyc();
        chk("bp_hold_v", 32'(p1_rsp_valid), 32'd1);
        chk("bp_hold_d", p1_rsp_data, 32'hDEADBEEF);
        p0_req = 0; p0_wEn = 0; p0_addr = 0;
        p1_rsp_ready = 1;
        #1;
        chk("bp_consume_rdy", 32'(p1_ready), 32'd1);
        cyc();
        chk("bp_new_v", 32'(p1_rsp_valid), 32'd1);
        chk("bp_new_d", p1_rsp_data, 32'h12345678);
        p1_valid = 0;
        cyc();
        chk("bp_drain", 32'(p1_rsp_valid), 32'd0);

        // idle bus and a sign-extended byte load
        clear_inputs();
        #1;
        chk("idle_wen", 32'(mem_WEN), 32'd0);
        chk("idle_addr", mem_Addr, 32'd0);
        p0_req = 1; p0_addr = 32'h23; p0_size = 0; p0_sign = 1;
        #1;
        chk("byte_size", 32'(mem_Size), 32'd0);
        chk("byte_sign", 32'(mem_sign), 32'd1);
        chk("byte_addr", mem_Addr, 32'h23);
        chk("byte_data", p0_rdata, 32'h00000012);
        p0_addr = 32'h30;
        #1;
        chk("byte_neg", p0_rdata, 32'hFFFFFFA5);
        cyc();
        clear_inputs();

        // reset while a response is pending
        p1_valid = 1; p1_addr = 32'h20; p1_size = 2;
        cyc();
        chk("mid_rspv", 32'(p1_rsp_valid), 32'd1);
        reset = 1;
        p0_req = 1; p0_wEn = 1; p0_addr = 32'h40; p0_wdata = 32'h11111111;
        p0_size = 2;
        #1;
        chk("mid_stall", 32'(p0_stall), 32'd1);
        chk("mid_rdy", 32'(p1_ready), 32'd0);
        chk("mid_wen", 32'(mem_WEN), 32'd0);
        cyc();
        reset = 0;
        clear_inputs();
        #1;
        chk("mid_rspv0", 32'(p1_rsp_valid), 32'd0);
        chk("mid_cnt0", 32'(dut.starve_cnt), 32'd0);
        chk("mid_nowrite", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]},
            32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
